// File: rtl/asic_iopwrseq_if.sv
// Control bundle between the IO power sequencer and the padring supply cells.
// Handshake: pwr_req is a level held by the requester; pwr_ack rises only
// after every domain is up and isolation is released, and falls as soon as a
// power-down, abort or fault begins. The requester must not treat the IO as
// usable unless pwr_req and pwr_ack are both 1.
interface asic_iopwrseq_if #(
    parameter int NDOM = 4,
    parameter int DW   = 8
) ();
    localparam int IW = (NDOM > 1) ? $clog2(NDOM) : 1;

    logic            pwr_req;
    logic [DW-1:0]   delay;
    logic [NDOM-1:0] pgood;
    logic [NDOM-1:0] pwr_en;
    logic [NDOM-1:0] iso_en;
    logic            pwr_ack;
    logic            fault;
    logic [IW-1:0]   fault_dom;
    logic [2:0]      dbg_state;

    modport master (
        output pwr_req, delay, pgood,
        input  pwr_en, iso_en, pwr_ack, fault, fault_dom, dbg_state
    );

    modport slave (
        input  pwr_req, delay, pgood,
        output pwr_en, iso_en, pwr_ack, fault, fault_dom, dbg_state
    );
endinterface

// File: rtl/asic_iopwrseq.sv
// Padring IO power-domain sequencer: ascending power-up with pgood wait and
// settle, isolation release when all domains are up, descending power-down,
// and a sticky fault path that drops every domain to the safe state.
module asic_iopwrseq #(
    parameter        TYPE    = "SOFT",
    parameter int    NDOM    = 4,
    parameter int    DW      = 8,
    parameter int    TIMEOUT = 64
) (
    input logic            clk,
    input logic            reset,
    asic_iopwrseq_if.slave io
);
    localparam int IW = (NDOM > 1) ? $clog2(NDOM) : 1;
    // The counter holds either a settle delay or the pgood timeout count.
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = (DW > TW) ? DW : TW;

    // Only the generic implementation exists; reject bad parameter sets early.
    if (TYPE != "SOFT") begin : g_type_chk
        $error("asic_iopwrseq: only the SOFT implementation is available");
    end
    if (NDOM < 2 || TIMEOUT < 1) begin : g_param_chk
        $error("asic_iopwrseq: NDOM must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_UP_WAIT = 3'd1,
        S_SETTLE  = 3'd2,
        S_ON      = 3'd3,
        S_DN_ISO  = 3'd4,
        S_DOWN    = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NDOM-1:0] pwr_en_q, pwr_en_nxt;
    logic [NDOM-1:0] iso_en_q, iso_en_nxt;
    logic            ack_q, ack_nxt;
    logic            fault_q, fault_nxt;
    logic [IW-1:0]   fdom_q, fdom_nxt;
    logic            mon_hit;
    logic [IW-1:0]   mon_dom;
    logic            tmo;

    // Find the lowest enabled domain that has lost pgood; the domain currently
    // ramping in UP_WAIT is allowed to be low.
    always_comb begin
        mon_hit = 1'b0;
        mon_dom = '0;
        if (state == S_SETTLE || state == S_ON || state == S_UP_WAIT) begin
            for (int j = NDOM - 1; j >= 0; j--) begin
                if (pwr_en_q[j] && !io.pgood[j] &&
                    !(state == S_UP_WAIT && idx == IW'(j))) begin
                    mon_hit = 1'b1;
                    mon_dom = IW'(j);
                end
            end
        end
    end

    // Timeout fires TIMEOUT+1 cycles after the domain's enable rose, so
    // pgood arriving in the last counted cycle is still accepted.
    assign tmo = (state == S_UP_WAIT) && !io.pgood[idx] && (cnt == CW'(TIMEOUT));

    // Next-state and next-output logic: fault detect, then abort, then normal flow.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        pwr_en_nxt = pwr_en_q;
        iso_en_nxt = iso_en_q;
        ack_nxt    = ack_q;
        fault_nxt  = fault_q;
        fdom_nxt   = fdom_q;
        if (mon_hit || tmo) begin
            state_nxt  = S_FAULT;
            pwr_en_nxt = '0;
            iso_en_nxt = '1;
            ack_nxt    = 1'b0;
            fault_nxt  = 1'b1;
            fdom_nxt   = mon_hit ? mon_dom : idx;
        end else if ((state == S_UP_WAIT || state == S_SETTLE) && !io.pwr_req) begin
            // Isolation is still clamped here, so go straight to the down walk.
            state_nxt       = S_DOWN;
            pwr_en_nxt[idx] = 1'b0;
            cnt_nxt         = CW'(io.delay);
        end else begin
            case (state)
                S_OFF: begin
                    if (io.pwr_req) begin
                        state_nxt     = S_UP_WAIT;
                        idx_nxt       = '0;
                        cnt_nxt       = '0;
                        pwr_en_nxt[0] = 1'b1;
                    end
                end
                S_UP_WAIT: begin
                    if (io.pgood[idx]) begin
                        state_nxt = S_SETTLE;
                        cnt_nxt   = CW'(io.delay);
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        if (idx == IW'(NDOM - 1)) begin
                            state_nxt  = S_ON;
                            iso_en_nxt = '0;
                            ack_nxt    = 1'b1;
                        end else begin
                            state_nxt                  = S_UP_WAIT;
                            idx_nxt                    = idx + IW'(1);
                            pwr_en_nxt[idx + IW'(1)]   = 1'b1;
                            cnt_nxt                    = '0;
                        end
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                S_ON: begin
                    if (!io.pwr_req) begin
                        state_nxt  = S_DN_ISO;
                        iso_en_nxt = '1;
                        ack_nxt    = 1'b0;
                    end
                end
                S_DN_ISO: begin
                    state_nxt                   = S_DOWN;
                    idx_nxt                     = IW'(NDOM - 1);
                    pwr_en_nxt[IW'(NDOM - 1)]   = 1'b0;
                    cnt_nxt                     = CW'(io.delay);
                end
                S_DOWN: begin
                    if (cnt == '0) begin
                        if (idx == '0) begin
                            state_nxt = S_OFF;
                        end else begin
                            idx_nxt                  = idx - IW'(1);
                            pwr_en_nxt[idx - IW'(1)] = 1'b0;
                            cnt_nxt                  = CW'(io.delay);
                        end
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                S_FAULT: begin
                    if (!io.pwr_req) begin
                        state_nxt = S_OFF;
                        fault_nxt = 1'b0;
                        idx_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt  = S_FAULT;
                    pwr_en_nxt = '0;
                    iso_en_nxt = '1;
                    ack_nxt    = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; reset lands every output in the safe state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_OFF;
            idx      <= '0;
            cnt      <= '0;
            pwr_en_q <= '0;
            iso_en_q <= '1;
            ack_q    <= 1'b0;
            fault_q  <= 1'b0;
            fdom_q   <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            cnt      <= cnt_nxt;
            pwr_en_q <= pwr_en_nxt;
            iso_en_q <= iso_en_nxt;
            ack_q    <= ack_nxt;
            fault_q  <= fault_nxt;
            fdom_q   <= fdom_nxt;
        end
    end

    assign io.pwr_en    = pwr_en_q;
    assign io.iso_en    = iso_en_q;
    assign io.pwr_ack   = ack_q;
    assign io.fault     = fault_q;
    assign io.fault_dom = fdom_q;
    assign io.dbg_state = state;
endmodule
